// File: rtl/adc2dac_align.sv
// adc2dac_align: per-channel delay line (circular buffer), any-to-any channel routing and
//   output mode (pass/zero/ramp/hold) on the ADC->DAC loopback path, 250 MHz domain.
// Latency: out_valid is in_valid delayed by exactly 2 cycles. No backpressure: every beat is accepted.
// Ports: clk_250m/rst_250m_n clock and async active-low reset; in_valid/in_data input beats
//   (channel c at [c*W +: W]); cfg_load/cfg_delay/cfg_sel/cfg_mode config latch pulse and fields;
//   out_valid/out_data registered DAC beats; cfg_err sticky flag for an out-of-range route select.
module adc2dac_align #(
  parameter int NCH   = 8,
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int DW    = 4,
  parameter int SW    = 3
) (
  input  logic              clk_250m,
  input  logic              rst_250m_n,
  input  logic              in_valid,
  input  logic [NCH*W-1:0]  in_data,
  input  logic              cfg_load,
  input  logic [NCH*DW-1:0] cfg_delay,
  input  logic [NCH*SW-1:0] cfg_sel,
  input  logic [1:0]        cfg_mode,
  output logic              out_valid,
  output logic [NCH*W-1:0]  out_data,
  output logic              cfg_err
);

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_ZERO = 2'd1;
  localparam logic [1:0] MODE_RAMP = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  // Active configuration
  logic [DW-1:0]    r_delay [NCH];
  logic [SW-1:0]    r_sel   [NCH];
  logic [1:0]       r_mode;

  // Delay line state
  logic [W-1:0]     r_buf   [NCH][DEPTH];
  logic [DW-1:0]    r_wr_ptr;
  logic [DW-1:0]    r_fill  [NCH];
  logic [W-1:0]     r_ramp;

  // Pipeline: stage 1 holds the computed beat, stage 2 is the output register
  logic             r_s1_vld;
  logic             r_s1_hold;
  logic [NCH*W-1:0] r_s1_dat;
  logic             r_out_vld;
  logic [NCH*W-1:0] r_out_dat;
  logic             r_cfg_err;

  logic [DW-1:0]    w_rd_addr [NCH];
  logic [W-1:0]     w_dly     [NCH];
  // Padded to the full select range so the route mux index is always in bounds
  logic [W-1:0]     w_dly_x   [2**SW];
  logic [NCH*W-1:0] w_moded;
  logic [SW-1:0]    w_new_sel [NCH];
  logic             w_sel_bad;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      // Natural DW-bit wrap gives the mod-DEPTH read address
      w_rd_addr[c] = r_wr_ptr - r_delay[c];
      if (r_fill[c] < r_delay[c]) begin
        w_dly[c] = '0;                         // not enough history yet
      end else if (r_delay[c] == '0) begin
        w_dly[c] = in_data[c*W +: W];          // slot at wr_ptr is being written this beat
      end else begin
        w_dly[c] = r_buf[c][w_rd_addr[c]];
      end
    end
    for (int s = 0; s < 2**SW; s++) w_dly_x[s] = '0;
    for (int c = 0; c < NCH; c++) w_dly_x[c] = w_dly[c];

    w_moded = '0;
    case (r_mode)
      MODE_PASS: for (int o = 0; o < NCH; o++) w_moded[o*W +: W] = w_dly_x[r_sel[o]];
      MODE_RAMP: for (int o = 0; o < NCH; o++) w_moded[o*W +: W] = r_ramp + W'(o);
      default:   w_moded = '0;                 // zero; hold ignores stage-1 data
    endcase
  end

  // Out-of-range selects are redirected to channel 0 and flagged
  always_comb begin
    w_sel_bad = 1'b0;
    for (int o = 0; o < NCH; o++) begin
      if ({{(32-SW){1'b0}}, cfg_sel[o*SW +: SW]} >= NCH) begin
        w_new_sel[o] = '0;
        w_sel_bad    = 1'b1;
      end else begin
        w_new_sel[o] = cfg_sel[o*SW +: SW];
      end
    end
  end

  // Sample storage needs no reset: fill counters mask anything written before reset
  always_ff @(posedge clk_250m) begin
    if (in_valid) begin
      for (int c = 0; c < NCH; c++) r_buf[c][r_wr_ptr] <= in_data[c*W +: W];
    end
  end

  always_ff @(posedge clk_250m or negedge rst_250m_n) begin
    if (!rst_250m_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_delay[c] <= '0;
        r_sel[c]   <= SW'(c);
        r_fill[c]  <= '0;
      end
      r_mode    <= MODE_PASS;
      r_wr_ptr  <= '0;
      r_ramp    <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_hold <= 1'b0;
      r_s1_dat  <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (in_valid) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_ramp   <= r_ramp + 1'b1;
        for (int c = 0; c < NCH; c++) begin
          if (r_fill[c] != DW'(DEPTH-1)) r_fill[c] <= r_fill[c] + 1'b1;
        end
      end

      // A beat in the same cycle as cfg_load has already used the old config;
      // the new one applies from the next beat, so loads here override the beat updates.
      if (cfg_load) begin
        for (int c = 0; c < NCH; c++) begin
          r_delay[c] <= cfg_delay[c*DW +: DW];
          if (cfg_delay[c*DW +: DW] != r_delay[c]) r_fill[c] <= '0;
          r_sel[c] <= w_new_sel[c];
        end
        r_mode <= cfg_mode;
        if (cfg_mode == MODE_RAMP) r_ramp <= '0;
        if (w_sel_bad) r_cfg_err <= 1'b1;
      end

      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_dat  <= w_moded;
        r_s1_hold <= (r_mode == MODE_HOLD);
      end

      r_out_vld <= r_s1_vld;
      if (r_s1_vld && !r_s1_hold) r_out_dat <= r_s1_dat;
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign cfg_err   = r_cfg_err;

endmodule
